// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes, FSM
// state encoding and the request classification / store lane helpers.
package rv_lsu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned F3_BITS = 3;
    localparam int unsigned LANES   = XLEN / 8;

    localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
    localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
    localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
    localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
    localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    // Illegal funct3 for the access direction, or address not naturally aligned.
    function automatic logic is_fault(
        input logic               we,
        input logic [F3_BITS-1:0] funct3,
        input logic [1:0]         addr_lo
    );
        logic bad_f3;
        logic misaligned;
        if (we) begin
            bad_f3 = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
        end else begin
            bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        case (funct3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        return bad_f3 || misaligned;
    endfunction

    // Byte-lane write enables for a legal, aligned store.
    function automatic logic [LANES-1:0] store_be(
        input logic [F3_BITS-1:0] funct3,
        input logic [1:0]         addr_lo
    );
        logic [LANES-1:0] be;
        case (funct3)
            F3_B:    be = 4'b0001 << addr_lo;
            F3_H:    be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data across every lane it may land on.
    function automatic logic [XLEN-1:0] store_data(
        input logic [F3_BITS-1:0] funct3,
        input logic [XLEN-1:0]    wdata
    );
        logic [XLEN-1:0] d;
        case (funct3)
            F3_B:    d = {4{wdata[7:0]}};
            F3_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv_lsu_align_if.sv
// Core request/response and RAM port bundle of the alignment unit.
// slave is the unit's view; master is the core+RAM side.
interface rv_lsu_align_if
    import rv_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) ();

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [F3_BITS-1:0]   req_funct3_i;
    logic [XLEN-1:0]      req_addr_i;
    logic [XLEN-1:0]      req_wdata_i;

    logic                 rsp_valid_o;
    logic [XLEN-1:0]      rsp_rdata_o;
    logic                 rsp_fault_o;

    logic                 mem_en_o;
    logic                 mem_we_o;
    logic [LANES-1:0]     mem_be_o;
    logic [ADDR_W-1:0]    mem_idx_o;
    logic [XLEN-1:0]      mem_wdata_o;
    logic [XLEN-1:0]      mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_fault_o,
        output mem_en_o, mem_we_o, mem_be_o, mem_idx_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_fault_o,
        input  mem_en_o, mem_we_o, mem_be_o, mem_idx_o, mem_wdata_o
    );

endinterface

// File: rtl/rv_load_align.sv
// Selects the addressed byte/half of a RAM word and sign- or zero-extends it.
module rv_load_align
    import rv_lsu_pkg::*;
(
    input  logic [XLEN-1:0]    word,
    input  logic [F3_BITS-1:0] funct3,
    input  logic [1:0]         addr_lo,
    output logic [XLEN-1:0]    data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by width/sign extension.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/rv_lsu_align.sv
// Load/store alignment unit between the core data port and a word-wide
// synchronous RAM with one cycle of read latency.
module rv_lsu_align
    import rv_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic          clk,
    input  logic          rst,
    rv_lsu_align_if.slave bus
);

    state_t             state;
    logic [F3_BITS-1:0] f3_q;
    logic [1:0]         lo_q;
    logic               rsp_valid_q;
    logic               rsp_fault_q;
    logic [XLEN-1:0]    rsp_rdata_q;

    logic               accept;
    logic               req_fault;
    logic [XLEN-1:0]    load_data;
    logic               unused_addr_hi;

    assign req_fault      = is_fault(bus.req_we_i, bus.req_funct3_i, bus.req_addr_i[1:0]);
    assign accept         = (state == IDLE) && bus.req_valid_i && !rst;
    // Upper address bits fall outside the RAM and simply wrap.
    assign unused_addr_hi = ^bus.req_addr_i[XLEN-1:ADDR_W+2];

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_fault_o = rsp_fault_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

    // RAM strobes are driven straight from the request in the accept cycle only.
    always_comb begin
        bus.req_ready_o = (state == IDLE) && !rst;
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_idx_o   = '0;
        bus.mem_wdata_o = '0;
        if (accept && !req_fault) begin
            bus.mem_en_o  = 1'b1;
            bus.mem_we_o  = bus.req_we_i;
            bus.mem_idx_o = bus.req_addr_i[ADDR_W+1:2];
            if (bus.req_we_i) begin
                bus.mem_be_o    = store_be(bus.req_funct3_i, bus.req_addr_i[1:0]);
                bus.mem_wdata_o = store_data(bus.req_funct3_i, bus.req_wdata_i);
            end
        end
    end

    rv_load_align u_load_align (
        .word    (bus.mem_rdata_i),
        .funct3  (f3_q),
        .addr_lo (lo_q),
        .data    (load_data)
    );

    // Request sequencing and registered response; reset drops any pending read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            f3_q        <= '0;
            lo_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_fault || bus.req_we_i) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= req_fault;
                            rsp_rdata_q <= '0;
                        end else begin
                            state <= RD_WAIT;
                            f3_q  <= bus.req_funct3_i;
                            lo_q  <= bus.req_addr_i[1:0];
                        end
                    end
                end
                RD_WAIT: begin
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_fault_q <= 1'b0;
                    rsp_rdata_q <= load_data;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rv_lsu_align.md
Name: rv_lsu_align

Overview:
Load/store alignment unit between the single-cycle core's data-memory port and a word-wide synchronous RAM (1-cycle read latency).
- Converts byte-address loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word index, byte-lane enables and lane-shifted write data.
- On loads, extracts the addressed byte/half from the returned word and sign- or zero-extends it.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
ADDR_W, 12, word-index width; RAM depth is 2**ADDR_W words (4096 words = 16 KiB).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid_i  in  1  request present
req_ready_o  out  1  unit can accept; request accepted when req_valid_i && req_ready_o
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RV32I funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW)
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-justified
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  32  extended load data; 0 for stores and faults
rsp_fault_o  out  1  misaligned or illegal funct3; valid with rsp_valid_o
mem_en_o  out  1  RAM access strobe
mem_we_o  out  1  RAM write
mem_be_o  out  4  RAM byte-lane write enables
mem_idx_o  out  ADDR_W  RAM word index = req_addr_i[ADDR_W+1:2]
mem_wdata_o  out  32  lane-shifted store data
mem_rdata_i  in  32  RAM read data, valid the cycle after mem_en_o with mem_we_o=0

Behaviour:
- Single clock. Reset is synchronous and active-high.
- FSM states: IDLE, RD_WAIT, RESP. req_ready_o = 1 only in IDLE and only when rst = 0.
- Reset values: state = IDLE, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_fault_o = 0.
- While rst = 1, all mem_* outputs and req_ready_o are forced to 0.
- mem_* outputs are combinational from the request during the IDLE accept cycle, and 0 in all other cycles.
- Fault: request is a fault if any of the following holds:
  - load funct3 is in {011, 110, 111};
  - store funct3 is > 010;
  - half-word access with addr[0] = 1;
  - word access with addr[1:0] != 00.
- Fault path: mem_en_o = 0; IDLE -> RESP; at T+1, rsp_valid_o = 1, rsp_fault_o = 1, rsp_rdata_o = 0.
- Store path, accept at T:
  - mem_en_o = mem_we_o = 1.
  - Byte enables: SB: be = 0001 << addr[1:0]; SH: be = 0011 << addr[1:0]; SW: be = 1111.
  - mem_wdata_o = req_wdata_i replicated per lane: SB {4{b}}, SH {2{h}}, SW word.
  - IDLE -> RESP; at T+1, rsp_valid_o = 1, rsp_rdata_o = 0.
- Load path, accept at T:
  - mem_en_o = 1, mem_we_o = 0, mem_be_o = 0000.
  - IDLE -> RD_WAIT; latch funct3 and addr[1:0].
  - At T+1, sample mem_rdata_i, align and extend it into rsp_rdata_o; RD_WAIT -> RESP.
  - At T+2, rsp_valid_o = 1.
- RESP -> IDLE unconditionally. rsp_valid_o is a single-cycle pulse with no back-pressure.
- Throughput: one store per 2 cycles, one load per 3 cycles.
- Address bits above ADDR_W+1 are ignored; the index wraps modulo 2**ADDR_W.
- If rst is asserted in RD_WAIT or RESP, no response is produced and the pending read data is discarded.
- If rst is asserted in the accept cycle, no write occurs.

Decomposition:
- Package rv_lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state typedef, function is_fault(we, funct3, addr_lo).
- Sub-module rv_load_align: purely combinational; inputs word, funct3, addr_lo; output extended 32-bit data. Instantiated once at the RD_WAIT capture.

Test Plan:
- SB addr 0x0000_1003, wdata 0x0000_00A5 -> at T: mem_en = 1, we = 1, be = 1000, idx = 0x400, wdata = 0xA5A5_A5A5; at T+1: rsp_valid = 1, fault = 0, rdata = 0.
- RAM word 0x400 = 0x1280_5678: LB at 0x1002 -> rsp_rdata = 0xFFFF_FF80 at T+2; LBU at 0x1002 -> 0x0000_0080; LB at 0x1001 -> 0x0000_0056.
- RAM word = 0x8001_1234: LH at 0x1002 -> 0xFFFF_8001; LHU at 0x1000 -> 0x0000_1234; LW at 0x1000 -> 0x8001_1234.
- LW at 0x1002, SH at 0x1001, and load funct3 = 011 -> mem_en never asserted; at T+1: rsp_valid = 1, fault = 1, rdata = 0.
- req_valid held high for back-to-back LW requests -> req_ready low in RD_WAIT/RESP; accepts exactly every 3rd cycle; responses in order.
- rst pulsed in RD_WAIT -> no rsp_valid; next cycle state = IDLE and req_ready = 1. Address 0x0001_4000 -> idx = 0x000 (wrap).
